// File: rtl/mult_share_sched_if.sv
// Request and response channels of the shared-multiplier scheduler.
// The requester side bundles NREQ request lanes; the response side
// carries one result at a time back to whichever lane was served.
interface mult_share_sched_if #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_p;
  logic                  rsp_err;

  // Requester / response-consumer side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err
  );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one combinational multiplier among NREQ
// requesters. Granted operands are registered onto the multiplier inputs,
// held for SETTLE cycles, then the product is captured, checked against a
// behavioural reference, and returned over a valid/ready response channel.
// A saturating counter scores how many products were wrong.
module mult_share_sched #(
  parameter int WIDTH  = 2,
  parameter int NREQ   = 4,
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_sched_if.slave    bus,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_p,
  output logic [ERRW-1:0]      err_count,
  output logic                 busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int PW   = 2 * WIDTH;
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  mult_a_q, mult_a_d;
  logic [WIDTH-1:0]  mult_b_q, mult_b_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [PW-1:0]     rsp_p_q, rsp_p_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ERRW-1:0]   err_count_q, err_count_d;

  logic [IDW-1:0]    cand_idx [NREQ];
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [PW-1:0]     prod_ref;
  logic [NREQ-1:0]   req_ready_c;
  logic              rsp_valid_c;
  logic              busy_c;

  // Reduce an index in [0, 2*NREQ) back into [0, NREQ); works for
  // non-power-of-two NREQ as well.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW:0] s);
    if (s >= (IDW+1)'(NREQ)) begin
      return IDW'(s - (IDW+1)'(NREQ));
    end
    return s[IDW-1:0];
  endfunction

  // Search order: lane ptr first, then upward, wrapping past NREQ-1.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand_idx[gi] = wrap_idx({1'b0, ptr_q} + (IDW+1)'(gi));
  end

  // Pick the first valid requester at or after ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign sel_a    = bus.req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b    = bus.req_b[grant_idx*WIDTH +: WIDTH];
  // Reference product at full output precision, from the held operands.
  assign prod_ref = PW'(mult_a_q) * PW'(mult_b_q);

  // State and datapath registers; everything clears immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic: grant -> settle countdown -> hold response until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found)       state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0)       state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready)     state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch operands on grant, capture product after
  // settling, advance pointer and score the result on response accept.
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          mult_a_d = sel_a;
          mult_b_d = sel_b;
          rsp_id_d = grant_idx;
          cnt_d    = CNTW'(SETTLE - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          rsp_p_d   = mult_p;
          rsp_err_d = (mult_p != prod_ref);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          ptr_d = wrap_idx({1'b0, rsp_id_q} + (IDW+1)'(1));
          if (rsp_err_q && (err_count_q != {ERRW{1'b1}})) begin
            err_count_d = err_count_q + ERRW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Moore outputs plus the combinational one-hot grant, which is forced
  // low while reset is held so no requester sees an accept it will lose.
  always_comb begin
    req_ready_c = '0;
    if ((state_q == S_IDLE) && grant_found && rst_n) begin
      req_ready_c[grant_idx] = 1'b1;
    end
    rsp_valid_c = (state_q == S_RESP);
    busy_c      = (state_q != S_IDLE);
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.rsp_err   = rsp_err_q;
  assign mult_a        = mult_a_q;
  assign mult_b        = mult_b_q;
  assign err_count     = err_count_q;
  assign busy          = busy_c;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched. Instance u0 (SETTLE=1, ERRW=2)
// covers single request, round-robin order, backpressure, wrap and the
// faulty-multiplier saturation; instance u1 (SETTLE=3) covers settle
// timing with a product glitch and reset in the middle of WAIT.
module tb_mult_share_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1;
  logic fault0, glitch1;
  logic [1:0] mult_a0, mult_b0, mult_a1, mult_b1;
  logic [3:0] mult_p0, mult_p1;
  logic [1:0] err_count0;
  logic [7:0] err_count1;
  logic busy0, busy1;

  int n_cmp = 0;
  int n_mis = 0;

  mult_share_sched_if #(.WIDTH(2), .NREQ(4)) if0 ();
  mult_share_sched_if #(.WIDTH(2), .NREQ(4)) if1 ();

  // Behavioural multipliers with fault / glitch injection
  assign mult_p0 = fault0  ? 4'd0 : 4'(mult_a0) * 4'(mult_b0);
  assign mult_p1 = glitch1 ? 4'd5 : 4'(mult_a1) * 4'(mult_b1);

  mult_share_sched #(.WIDTH(2), .NREQ(4), .SETTLE(1), .ERRW(2)) u0 (
    .clk(clk), .rst_n(rst_n0), .bus(if0.slave),
    .mult_a(mult_a0), .mult_b(mult_b0), .mult_p(mult_p0),
    .err_count(err_count0), .busy(busy0)
  );

  mult_share_sched #(.WIDTH(2), .NREQ(4), .SETTLE(3), .ERRW(8)) u1 (
    .clk(clk), .rst_n(rst_n1), .bus(if1.slave),
    .mult_a(mult_a1), .mult_b(mult_b1), .mult_p(mult_p1),
    .err_count(err_count1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_prod [4];

  initial begin
    rr_prod[0] = 4'd3; rr_prod[1] = 4'd9; rr_prod[2] = 4'd4; rr_prod[3] = 4'd6;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    fault0 = 1'b0; glitch1 = 1'b0;
    if0.req_valid = 4'b0001; if0.req_a = 8'hFF; if0.req_b = 8'hFF; if0.rsp_ready = 1'b1;
    if1.req_valid = 4'b0000; if1.req_a = 8'h00; if1.req_b = 8'h00; if1.rsp_ready = 1'b1;

    // ---- reset values ----
    #3;
    check("rst_req_ready", 32'(if0.req_ready), 32'd0);
    check("rst_mult_a",    32'(mult_a0), 32'd0);
    check("rst_mult_b",    32'(mult_b0), 32'd0);
    check("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(if0.rsp_id), 32'd0);
    check("rst_rsp_p",     32'(if0.rsp_p), 32'd0);
    check("rst_rsp_err",   32'(if0.rsp_err), 32'd0);
    check("rst_err_count", 32'(err_count0), 32'd0);
    check("rst_busy",      32'(busy0), 32'd0);
    tick(); tick();
    check("rst_hold_mult_a", 32'(mult_a0), 32'd0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;

    // ---- single request: requester 0, 2*3 ----
    if0.req_a = 8'h02; if0.req_b = 8'h03; if0.req_valid = 4'b0001;
    #1;
    check("single_grant", 32'(if0.req_ready), 32'b0001);
    tick();
    check("single_mult_a", 32'(mult_a0), 32'd2);
    check("single_mult_b", 32'(mult_b0), 32'd3);
    check("single_ready_off", 32'(if0.req_ready), 32'd0);
    check("single_busy", 32'(busy0), 32'd1);
    check("single_no_rsp_yet", 32'(if0.rsp_valid), 32'd0);
    if0.req_valid = 4'b0000;
    tick();
    check("single_rsp_valid", 32'(if0.rsp_valid), 32'd1);
    check("single_rsp_id", 32'(if0.rsp_id), 32'd0);
    check("single_rsp_p", 32'(if0.rsp_p), 32'd6);
    check("single_rsp_err", 32'(if0.rsp_err), 32'd0);
    tick();
    check("single_done_valid", 32'(if0.rsp_valid), 32'd0);
    check("single_done_busy", 32'(busy0), 32'd0);
    check("single_operand_kept", 32'(mult_a0), 32'd2);

    // restart u0 so arbitration begins at requester 0
    rst_n0 = 1'b0;
    #1;
    check("async_rst_mult_a", 32'(mult_a0), 32'd0);
    tick();
    rst_n0 = 1'b1;

    // ---- round robin: (1,3) (3,3) (2,2) (3,2) ----
    if0.req_a = 8'hED; if0.req_b = 8'hAF; if0.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d_grant", k), 32'(if0.req_ready), 32'(4'b0001 << (k % 4)));
      tick(); tick();
      check($sformatf("rr%0d_id", k), 32'(if0.rsp_id), 32'(k % 4));
      check($sformatf("rr%0d_p", k), 32'(if0.rsp_p), 32'(rr_prod[k % 4]));
      tick();
    end

    // ---- backpressure, with wrap from ptr=1 back to requester 0 ----
    if0.req_valid = 4'b0001; if0.rsp_ready = 1'b0;
    #1;
    check("wrap_grant", 32'(if0.req_ready), 32'b0001);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), 32'(if0.rsp_valid), 32'd1);
      check($sformatf("bp%0d_id", k), 32'(if0.rsp_id), 32'd0);
      check($sformatf("bp%0d_p", k), 32'(if0.rsp_p), 32'd3);
      check($sformatf("bp%0d_ready", k), 32'(if0.req_ready), 32'd0);
      tick();
    end
    if0.rsp_ready = 1'b1;
    tick();
    if0.req_valid = 4'b0000;
    check("bp_accept_valid", 32'(if0.rsp_valid), 32'd0);
    check("bp_accept_busy", 32'(busy0), 32'd0);
    check("bp_err_count", 32'(err_count0), 32'd0);

    // ---- faulty multiplier: 3*3 returns 0, counter saturates at 3 ----
    fault0 = 1'b1; if0.req_a = 8'h03; if0.req_b = 8'h03; if0.req_valid = 4'b0001;
    for (int j = 1; j <= 5; j++) begin
      tick(); tick();
      check($sformatf("fault%0d_p", j), 32'(if0.rsp_p), 32'd0);
      check($sformatf("fault%0d_err", j), 32'(if0.rsp_err), 32'd1);
      tick();
      check($sformatf("fault%0d_count", j), 32'(err_count0), 32'((j > 3) ? 3 : j));
    end
    if0.req_valid = 4'b0000; fault0 = 1'b0;

    // ---- settle timing on u1 (SETTLE=3): requester 1, 3*2 ----
    if1.req_a = 8'h0C; if1.req_b = 8'h08; if1.req_valid = 4'b0010;
    #1;
    check("settle_grant", 32'(if1.req_ready), 32'b0010);
    tick();
    check("settle_mult_a", 32'(mult_a1), 32'd3);
    check("settle_mult_b", 32'(mult_b1), 32'd2);
    if1.req_valid = 4'b0000; if1.req_a = 8'hFF; if1.req_b = 8'hFF;
    glitch1 = 1'b1;
    tick();
    check("settle_t1_valid", 32'(if1.rsp_valid), 32'd0);
    tick();
    check("settle_t2_valid", 32'(if1.rsp_valid), 32'd0);
    check("settle_hold_a", 32'(mult_a1), 32'd3);
    glitch1 = 1'b0;
    tick();
    check("settle_t3_valid", 32'(if1.rsp_valid), 32'd1);
    check("settle_t3_id", 32'(if1.rsp_id), 32'd1);
    check("settle_t3_p", 32'(if1.rsp_p), 32'd6);
    check("settle_t3_err", 32'(if1.rsp_err), 32'd0);
    tick();
    check("settle_done_busy", 32'(busy1), 32'd0);

    // ---- reset mid-WAIT on u1 (ptr is 2 here) ----
    if1.req_a = 8'h01; if1.req_b = 8'h01; if1.req_valid = 4'b0001;
    tick();
    check("midwait_busy", 32'(busy1), 32'd1);
    if1.req_valid = 4'b0000;
    tick();
    rst_n1 = 1'b0; if1.req_valid = 4'b0100;
    #1;
    check("midwait_rst_busy", 32'(busy1), 32'd0);
    check("midwait_rst_mult_a", 32'(mult_a1), 32'd0);
    check("midwait_rst_mult_b", 32'(mult_b1), 32'd0);
    check("midwait_rst_valid", 32'(if1.rsp_valid), 32'd0);
    check("midwait_rst_ready", 32'(if1.req_ready), 32'd0);
    if1.req_valid = 4'b0000;
    tick(); tick();
    rst_n1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("midwait_quiet%0d", k), 32'(if1.rsp_valid), 32'd0);
      tick();
    end
    // requesters 0 and 2: restart from ptr=0 must choose 0
    if1.req_a = 8'h32; if1.req_b = 8'h32; if1.req_valid = 4'b0101;
    #1;
    check("restart_grant", 32'(if1.req_ready), 32'b0001);
    tick();
    if1.req_valid = 4'b0100;
    tick(); tick(); tick();
    check("restart_rsp_id", 32'(if1.rsp_id), 32'd0);
    check("restart_rsp_p", 32'(if1.rsp_p), 32'd4);
    tick();
    check("req2_grant", 32'(if1.req_ready), 32'b0100);
    tick();
    if1.req_valid = 4'b0000;
    tick(); tick(); tick();
    check("req2_rsp_id", 32'(if1.rsp_id), 32'd2);
    check("req2_rsp_p", 32'(if1.rsp_p), 32'd9);
    tick();
    check("req2_done_busy", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
